// File: rtl/vlsu_pkg.sv
// ----------------------------------------------------------------------------
// vlsu_pkg
//   Shared types and helpers for the vector load/store unit.
//   - state_t  : control FSM states
//   - cmd_t    : command fields captured when a start is accepted
//   - VLEN_MAX : maximum element count per vector register
//   - clamp_vl : saturates the requested vl to VLEN_MAX
// ----------------------------------------------------------------------------
package vlsu_pkg;

    localparam int VLEN_MAX = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic       is_store;
        logic [2:0] vl;       // already clamped, 0..VLEN_MAX
        logic [4:0] vreg;
    } cmd_t;

    // Requests above the register length saturate rather than wrap.
    function automatic logic [2:0] clamp_vl(input logic [2:0] vl);
        return (vl > 3'(VLEN_MAX)) ? 3'(VLEN_MAX) : vl;
    endfunction

endpackage

// File: rtl/vlsu_addr_gen.sv
// ----------------------------------------------------------------------------
// vlsu_addr_gen
//   Element address generator. Loads the base address and the per-element
//   step when a command is accepted, then adds the step after every accepted
//   memory request. Arithmetic wraps modulo 2^ADDR_W.
//
//   Build option VLSU_STRIDE_EN:
//     defined   - step is the signed stride input (negative strides wrap
//                 naturally in two's complement)
//     undefined - unit stride, step = SEW/8 bytes; stride input is ignored
//
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     load       command accepted: capture base and step
//     advance    request handshake: move to the next element
//     base       byte address of element 0
//     stride     signed byte stride
//     addr       current element address
// ----------------------------------------------------------------------------
module vlsu_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int SEW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] step_sel;
    logic [ADDR_W-1:0] step_q;
    logic [ADDR_W-1:0] addr_q;

`ifdef VLSU_STRIDE_EN
    assign step_sel = stride;
`else
    localparam logic [ADDR_W-1:0] UNIT_STEP = ADDR_W'(SEW / 8);
    // Port kept so both builds share one interface; its value is don't-care.
    logic unused_stride;
    assign unused_stride = ^stride;
    assign step_sel      = UNIT_STEP;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            step_q <= '0;
        end else if (load) begin
            addr_q <= base;
            step_q <= step_sel;
        end else if (advance) begin
            addr_q <= addr_q + step_q;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/vector_lsu.sv
// ----------------------------------------------------------------------------
// vector_lsu
//   Vector load/store unit between the vector register file and a
//   single-ported, word-wide data memory. Moves up to VLEN SEW-bit elements
//   one at a time. Loads gather into a local buffer (pre-filled with the
//   register contents so tail elements stay undisturbed) and retire with one
//   whole-register write pulse; stores stream the buffer sampled at start.
//
//   Build option VLSU_STRIDE_EN (see vlsu_addr_gen): strided vs unit-stride.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     start, is_store, vl,     command; accepted only while idle
//     base_addr, stride, vreg
//     src_data0..3             register contents sampled at start
//     mem_req/we/addr/wdata    memory request, held stable until mem_ready
//     mem_ready                request accepted when mem_req && mem_ready
//     mem_rvalid, mem_rdata    load response (only honoured while waiting)
//     reg_write, wr_reg,       one-cycle register file write for loads
//     write_data0..3
//     busy                     not idle
//     done                     one-cycle completion pulse
//
//   All outputs decode from registered state, so there is no combinational
//   path from start to the memory request.
// ----------------------------------------------------------------------------
module vector_lsu
    import vlsu_pkg::*;
#(
    parameter int VLEN   = 4,
    parameter int SEW    = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        vl,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [4:0]        vreg,
    input  logic [SEW-1:0]    src_data0,
    input  logic [SEW-1:0]    src_data1,
    input  logic [SEW-1:0]    src_data2,
    input  logic [SEW-1:0]    src_data3,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [SEW-1:0]    mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [SEW-1:0]    mem_rdata,
    output logic              reg_write,
    output logic [4:0]        wr_reg,
    output logic [SEW-1:0]    write_data0,
    output logic [SEW-1:0]    write_data1,
    output logic [SEW-1:0]    write_data2,
    output logic [SEW-1:0]    write_data3,
    output logic              busy,
    output logic              done
);

    state_t                     state_q, state_d;
    cmd_t                       cmd_q;
    logic [1:0]                 idx_q;
    logic [VLEN-1:0][SEW-1:0]   ebuf_q;

    logic       start_ok;
    logic [2:0] vl_c;
    logic       req_hs;
    logic       rsp_ok;
    logic       last;

    assign vl_c     = clamp_vl(vl);
    assign start_ok = (state_q == IDLE) && start;
    assign req_hs   = (state_q == REQ) && mem_ready;
    // Responses are only legal while waiting; anything else is noise.
    assign rsp_ok   = (state_q == WAIT) && mem_rvalid;
    assign last     = (({1'b0, idx_q} + 3'd1) == cmd_q.vl);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)      state_d = (vl_c == 3'd0) ? DONE : REQ;
            REQ:  if (mem_ready) begin
                      if (cmd_q.is_store) state_d = last ? DONE : REQ;
                      else                state_d = WAIT;
                  end
            WAIT: if (mem_rvalid) state_d = last ? WB : REQ;
            WB:                   state_d = DONE;
            DONE:                 state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    // Stores advance the index on the request handshake, loads on the
    // response, so idx always names the element currently in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q  <= '0;
            idx_q  <= '0;
            ebuf_q <= '0;
        end else if (start_ok) begin
            cmd_q  <= '{is_store: is_store, vl: vl_c, vreg: vreg};
            idx_q  <= '0;
            ebuf_q <= {src_data3, src_data2, src_data1, src_data0};
        end else if (req_hs && cmd_q.is_store) begin
            idx_q  <= idx_q + 2'd1;
        end else if (rsp_ok) begin
            ebuf_q[idx_q] <= mem_rdata;
            idx_q         <= idx_q + 2'd1;
        end
    end

    vlsu_addr_gen #(
        .ADDR_W (ADDR_W),
        .SEW    (SEW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (start_ok),
        .advance (req_hs),
        .base    (base_addr),
        .stride  (stride),
        .addr    (mem_addr)
    );

    // ------------------------------------------------------------ outputs
    assign mem_req     = (state_q == REQ);
    assign mem_we      = mem_req && cmd_q.is_store;
    assign mem_wdata   = mem_req ? ebuf_q[idx_q] : '0;
    assign reg_write   = (state_q == WB);
    assign wr_reg      = cmd_q.vreg;
    assign write_data0 = ebuf_q[0];
    assign write_data1 = ebuf_q[1];
    assign write_data2 = ebuf_q[2];
    assign write_data3 = ebuf_q[3];
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule
